// File: rtl/coef_buf_rd_ctrl.sv
// Read-side controller for the coefficient buffer: streams rows 0..len out of a 1-cycle RAM
// through a 2-entry skid FIFO. Optional coded-block flag is built when COEF_RD_CBF_EN is defined.
module coef_buf_rd_ctrl #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic              b_re_o,
    output logic [ADDR_W-1:0] b_addr_o,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cbf_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] r_fifo_data [2];
    logic              r_fifo_last [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_cnt;

    logic w_pop;
    logic w_push;
    logic w_credit;
    logic w_re;
    logic w_rd_last;
    logic w_start;
    logic w_drain_done;

    // Credit counts the entry being popped this cycle as already free, so the FIFO never exceeds 2.
    assign w_pop        = (r_cnt != 2'd0) && out_ready_i;
    assign w_push       = r_inflight;
    assign w_credit     = ({1'b0, r_cnt} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign w_re         = (r_state == ST_READ) && w_credit;
    assign w_rd_last    = (r_rd_addr == r_len);
    assign w_start      = start_i && !r_busy;
    assign w_drain_done = !r_inflight && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop));

    assign b_re_o      = w_re;
    assign b_addr_o    = r_rd_addr;
    assign out_valid_o = (r_cnt != 2'd0);
    assign out_data_o  = r_fifo_data[r_rptr];
    assign out_last_o  = r_fifo_last[r_rptr];
    assign busy_o      = r_busy;
    assign done_o      = r_done;

    // Skid FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wptr] <= b_data_i;
                r_fifo_last[r_wptr] <= r_inflight_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 2'd1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 2'd1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Block sequencing FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_len           <= '0;
            r_rd_addr       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_inflight      <= w_re;
            r_inflight_last <= w_re && w_rd_last;
            r_done          <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_len     <= len_i;
                        r_rd_addr <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_READ;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    // The address parks on the last row instead of wrapping.
                    if (w_re) begin
                        if (w_rd_last) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_rd_addr <= r_rd_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef COEF_RD_CBF_EN
    logic r_cbf_acc;
    logic r_cbf;

    // Coded-block flag: OR of every popped row, published on the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cbf_acc <= 1'b0;
            r_cbf     <= 1'b0;
        end else if (w_start) begin
            r_cbf_acc <= 1'b0;
            r_cbf     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_cbf_acc <= r_cbf_acc | (|out_data_o);
            end
            if ((r_state == ST_DRAIN) && w_drain_done) begin
                r_cbf <= r_cbf_acc | (w_pop & (|out_data_o));
            end
        end
    end

    assign cbf_o = r_cbf;
`else
    assign cbf_o = 1'b0;
`endif

endmodule

// File: tb/tb_coef_buf_rd_ctrl.sv
// Randomized bench for coef_buf_rd_ctrl: a row-sequence model of each block checks every
// accepted beat, read address/credit, busy/done timing and (with COEF_RD_CBF_EN) the coded-block flag.
module tb_coef_buf_rd_ctrl;
    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] len_i;
    logic          b_re_o;
    logic [AW-1:0] b_addr_o;
    logic [DW-1:0] b_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          out_last_o;
    logic          busy_o;
    logic          done_o;
    logic          cbf_o;

    coef_buf_rd_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
        .b_re_o(b_re_o), .b_addr_o(b_addr_o), .b_data_i(b_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o),
        .busy_o(busy_o), .done_o(done_o), .cbf_o(cbf_o)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:31];
    always @(posedge clk) begin
        if (b_re_o) b_data_i <= ram[b_addr_o];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model of one block: rows 0..m_len leave in order, one per accepted beat.
    bit            m_active, m_done_due, m_done_seen, m_acc, m_cbf, stall_prev;
    int            m_len, m_issued, m_pops, rdy_pct, step_no;
    int            start_step, first_valid_step, first_pop_step, last_pop_step;
    logic [DW-1:0] data_prev;

    task automatic step(input bit st, input bit rs);
        bit pop, busy_exp;
        @(negedge clk);
        start_i     = st;
        rst         = rs;
        out_ready_i = ($urandom_range(99) < rdy_pct);
        #1;
        step_no++;
        pop      = out_valid_o && out_ready_i;
        busy_exp = m_active && !m_done_due;
        check_eq("busy", 64'(busy_o), 64'(busy_exp));
        check_eq("done", 64'(done_o), 64'(m_done_due));
        check_eq("cbf", 64'(cbf_o), 64'(m_cbf));
        if (out_valid_o) begin
            check_eq("valid_without_read", 64'(m_pops < m_issued), 64'd1);
            if (first_valid_step < 0) first_valid_step = step_no;
        end
        if (stall_prev) begin
            check_eq("stall_valid", 64'(out_valid_o), 64'd1);
            check_eq("stall_data", out_data_o, data_prev);
        end
        if (b_re_o) begin
            check_eq("re_outside_block", 64'(m_active), 64'd1);
            check_eq("addr", 64'(b_addr_o), 64'(m_issued));
            check_eq("addr_bound", 64'(m_issued <= m_len), 64'd1);
            check_eq("credit", 64'((m_issued - m_pops - int'(pop)) < 2), 64'd1);
            m_issued++;
        end
        if (pop) begin
            check_eq("data", out_data_o, ram[m_pops]);
            check_eq("last", 64'(out_last_o), 64'(m_pops == m_len));
            m_acc = m_acc | (|ram[m_pops]);
            if (first_pop_step < 0) first_pop_step = step_no;
            last_pop_step = step_no;
            m_pops++;
        end
        stall_prev = out_valid_o && !out_ready_i;
        data_prev  = out_data_o;
        if (m_done_due) begin
            m_done_due  = 1'b0;
            m_active    = 1'b0;
            m_done_seen = 1'b1;
        end
        if (pop && (m_pops == m_len + 1)) begin
            m_done_due = 1'b1;
`ifdef COEF_RD_CBF_EN
            m_cbf = m_acc;
`endif
        end
        if (st && !busy_exp) begin
            m_active = 1'b1; m_len = int'(len_i); m_issued = 0; m_pops = 0;
            m_acc = 1'b0; m_cbf = 1'b0; m_done_seen = 1'b0;
            start_step = step_no; first_valid_step = -1; first_pop_step = -1; last_pop_step = -1;
        end
        if (rs) begin
            m_active = 1'b0; m_done_due = 1'b0; m_issued = 0; m_pops = 0;
            m_acc = 1'b0; m_cbf = 1'b0; stall_prev = 1'b0;
        end
    endtask

    task automatic run_block(input int len, input int pct);
        int budget;
        len_i   = AW'(len);
        rdy_pct = pct;
        step(1'b1, 1'b0);
        budget = 0;
        while (!m_done_seen && budget < 800) begin
            step(1'b0, 1'b0);
            budget++;
        end
        check_eq("block_timeout", 64'(m_done_seen), 64'd1);
        check_eq("beats", 64'(m_pops), 64'(len + 1));
        check_eq("reads", 64'(m_issued), 64'(len + 1));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_re"}, 64'(b_re_o), 64'd0);
        check_eq({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy_o), 64'd0);
        check_eq({tag, "_done"}, 64'(done_o), 64'd0);
    endtask

    initial begin
        int budget;
        for (int k = 0; k < 32; k++) ram[k] = {$urandom, $urandom};
        rst = 1'b1; start_i = 1'b0; len_i = '0; out_ready_i = 1'b0; rdy_pct = 0;
        m_active = 0; m_done_due = 0; m_done_seen = 0; m_acc = 0; m_cbf = 0; stall_prev = 0;
        m_len = 0; m_issued = 0; m_pops = 0; step_no = 0; data_prev = '0;
        start_step = 0; first_valid_step = -1; first_pop_step = -1; last_pop_step = -1;
        repeat (3) @(posedge clk);

        // T1: after reset release, all outputs stay 0 without a start.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            check_idle("t1");
            check_eq("t1_last", 64'(out_last_o), 64'd0);
            check_eq("t1_data", out_data_o, 64'd0);
            check_eq("t1_cbf", 64'(cbf_o), 64'd0);
        end

        // T2: full 32-row block with ready held high.
        for (int k = 0; k < 32; k++) ram[k] = {8{8'(k)}};
        run_block(31, 100);
        check_eq("t2_first_valid_latency", 64'(first_valid_step - start_step), 64'd3);
        check_eq("t2_back_to_back", 64'(last_pop_step - first_pop_step), 64'd31);
        step(1'b0, 1'b0);
        check_idle("t2_after");

        // T3: single-row block.
        run_block(0, 100);

        // T4: 16 rows under random backpressure, then a few more random blocks.
        for (int k = 0; k < 32; k++) ram[k] = {$urandom, $urandom};
        run_block(15, 70);
        for (int b = 0; b < 4; b++) run_block($urandom_range(31), $urandom_range(30, 90));

        // T5: start while busy is ignored; reset at beat 5 aborts the block.
        len_i = AW'(20); rdy_pct = 80;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        len_i = AW'(3);
        step(1'b1, 1'b0);
        budget = 0;
        while (m_pops < 5 && budget < 200) begin
            step(1'b0, 1'b0);
            budget++;
        end
        check_eq("t5_reach_beat5", 64'(m_pops >= 5), 64'd1);
        check_eq("t5_len_kept", 64'(m_len), 64'd20);
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check_idle("t5_post_rst");
        end
        run_block(7, 100);

        // T6: coded-block flag for an all-zero block and for a block with one set bit.
        for (int k = 0; k < 32; k++) ram[k] = '0;
        run_block(31, 100);
        check_eq("t6_cbf_zero", 64'(cbf_o), 64'd0);
        ram[7] = 64'h1;
        run_block(15, 60);
`ifdef COEF_RD_CBF_EN
        check_eq("t6_cbf_one", 64'(cbf_o), 64'd1);
`else
        check_eq("t6_cbf_tied", 64'(cbf_o), 64'd0);
`endif
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
